// File: rtl/param_calc_pkg.sv
// Shared types and constants for the switch calculator.
// No logic, so no latency.
// No flow control.
package param_calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_e;

    typedef struct packed {
        logic n;
        logic zf;
        logic c;
        logic v;
    } flags_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] DISP_RES_OP    = 2'b00;
    localparam logic [1:0] DISP_OPERANDS  = 2'b01;
    localparam logic [1:0] DISP_RES_FLAGS = 2'b10;
    localparam logic [1:0] DISP_OFF       = 2'b11;

endpackage

// File: rtl/param_calculator_if.sv
// Board-side signals of the calculator: switches, button, LEDs and digits.
// No logic, so no latency.
// No flow control; switches are sampled every clock.
interface param_calculator_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] Z;
    logic [WIDTH-1:0] Y;
    logic [1:0]       mode;
    logic             btn_change;
    logic [6:0]       segA;
    logic [6:0]       segB;
    logic [WIDTH-1:0] out;

    modport master (
        output Z, Y, mode, btn_change,
        input  segA, segB, out
    );

    modport slave (
        input  Z, Y, mode, btn_change,
        output segA, segB, out
    );
endinterface

// File: rtl/seven_seg_decoder.sv
// Hex digit to active-low seven-segment pattern (bit0=a .. bit6=g).
// Combinational, zero latency.
// No flow control.
module seven_seg_decoder (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Font lookup for digits 0-9 and A, b, C, d, E, F.
    always_comb begin
        seg = 7'h7F;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/param_calculator.sv
// Switch calculator: debounced key steps through eight ALU ops, result to LEDs and digits.
// Operand/op change reaches out, flags and both digits one clock later.
// No backpressure; the key press is accepted once per debounced low period.
module param_calculator
    import param_calc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEB_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    param_calculator_if.slave bus
);

    localparam int MSB = WIDTH - 1;
    localparam logic [DEB_W-1:0] DEB_MAX = '1;

    logic             btn_s1;
    logic             btn_s2;
    logic [DEB_W-1:0] deb_cnt;
    logic             pressed;
    op_e              op_idx;

    logic [WIDTH:0]       sum_ext;
    logic [WIDTH:0]       diff_ext;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   shl_ext;
    logic [2*WIDTH-1:0]   shr_ext;
    logic [WIDTH-1:0]     res;
    flags_t               flags_nxt;
    flags_t               flags;
    logic [3:0]           nib_a;
    logic [3:0]           nib_b;
    logic [6:0]           dec_a;
    logic [6:0]           dec_b;

    // Synchronise the key, count stable-low clocks and step the op once per press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1  <= 1'b1;
            btn_s2  <= 1'b1;
            deb_cnt <= '0;
            pressed <= 1'b0;
            op_idx  <= OP_ADD;
        end else begin
            btn_s1 <= bus.btn_change;
            btn_s2 <= btn_s1;
            if (btn_s2) begin
                deb_cnt <= '0;
                pressed <= 1'b0;
            end else if (deb_cnt != DEB_MAX) begin
                deb_cnt <= deb_cnt + 1'b1;
            end else if (!pressed) begin
                pressed <= 1'b1;
                op_idx  <= op_e'(3'(op_idx) + 3'd1);
            end
        end
    end

    // Extended-width arithmetic so carries, borrows and shifted-out bits are visible.
    assign sum_ext  = {1'b0, bus.Z} + {1'b0, bus.Y};
    assign diff_ext = {1'b0, bus.Z} - {1'b0, bus.Y};
    assign prod     = {{WIDTH{1'b0}}, bus.Z} * {{WIDTH{1'b0}}, bus.Y};
    assign shl_ext  = {{WIDTH{1'b0}}, bus.Z} << bus.Y;
    assign shr_ext  = {bus.Z, {WIDTH{1'b0}}} >> bus.Y;

    // ALU result and flags for the current op.
    always_comb begin
        res          = '0;
        flags_nxt    = '0;
        case (op_idx)
            OP_ADD: begin
                res         = sum_ext[MSB:0];
                flags_nxt.c = sum_ext[WIDTH];
                flags_nxt.v = (bus.Z[MSB] == bus.Y[MSB]) && (sum_ext[MSB] != bus.Z[MSB]);
            end
            OP_SUB: begin
                res         = diff_ext[MSB:0];
                flags_nxt.c = diff_ext[WIDTH];
                flags_nxt.v = (bus.Z[MSB] != bus.Y[MSB]) && (diff_ext[MSB] != bus.Z[MSB]);
            end
            OP_MUL: begin
                res         = prod[MSB:0];
                flags_nxt.c = |prod[2*WIDTH-1:WIDTH];
                flags_nxt.v = |prod[2*WIDTH-1:WIDTH];
            end
            OP_AND: res = bus.Z & bus.Y;
            OP_OR:  res = bus.Z | bus.Y;
            OP_XOR: res = bus.Z ^ bus.Y;
            // Bit WIDTH of the extended shift is the last bit pushed past the top.
            OP_SHL: begin
                res         = shl_ext[MSB:0];
                flags_nxt.c = shl_ext[WIDTH];
            end
            // Bit WIDTH-1 of the extended shift is the last bit pushed past the bottom.
            OP_SHR: begin
                res         = shr_ext[2*WIDTH-1:WIDTH];
                flags_nxt.c = shr_ext[MSB];
            end
            default: res = '0;
        endcase
        flags_nxt.n  = res[MSB];
        flags_nxt.zf = (res == '0);
    end

    // Digit sources chosen from the same-cycle values that feed the result register.
    always_comb begin
        nib_a = 4'(res);
        nib_b = {1'b0, op_idx};
        case (bus.mode)
            DISP_OPERANDS: begin
                nib_a = 4'(bus.Z);
                nib_b = 4'(bus.Y);
            end
            DISP_RES_FLAGS: nib_b = flags_nxt;
            default: ;
        endcase
    end

    seven_seg_decoder u_dec_a (.hex(nib_a), .seg(dec_a));
    seven_seg_decoder u_dec_b (.hex(nib_b), .seg(dec_b));

    // Register result, flags and both digits together so they always agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out  <= '0;
            flags    <= '0;
            bus.segA <= SEG_BLANK;
            bus.segB <= SEG_BLANK;
        end else begin
            bus.out <= res;
            flags   <= flags_nxt;
            if (bus.mode == DISP_OFF) begin
                bus.segA <= SEG_BLANK;
                bus.segB <= SEG_BLANK;
            end else begin
                bus.segA <= dec_a;
                bus.segB <= dec_b;
            end
        end
    end

endmodule

// File: tb/tb_param_calculator.sv
// Self-checking bench for param_calculator against an arithmetic reference model.
module tb_param_calculator;

    localparam int W     = 4;
    localparam int DEB_W = 4;
    localparam int HOLD  = 2**DEB_W + 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    param_calculator_if #(.WIDTH(W)) bus ();

    param_calculator #(.WIDTH(W), .DEB_W(DEB_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int vectors    = 0;
    int miscompares = 0;
    int m_op       = 0;

    // Reference ALU: plain integer arithmetic on 4-bit unsigned values.
    function automatic void model(input int op, input int z, input int y,
                                  output int r, output int flg);
        int s, sz, sy, c, v;
        c  = 0;
        v  = 0;
        sz = (z >= 8) ? z - 16 : z;
        sy = (y >= 8) ? y - 16 : y;
        case (op)
            0: begin s = z + y; r = s % 16; c = (s > 15); v = (sz + sy > 7) || (sz + sy < -8); end
            1: begin r = (z - y + 16) % 16; c = (z < y); v = (sz - sy > 7) || (sz - sy < -8); end
            2: begin s = z * y; r = s % 16; c = (s > 15); v = c; end
            3: r = z & y;
            4: r = z | y;
            5: r = z ^ y;
            6: begin
                r = (y >= 4) ? 0 : (z << y) % 16;
                c = (y >= 1 && y <= 4) ? (z >> (4 - y)) & 1 : 0;
            end
            default: begin
                r = z >> y;
                c = (y >= 1 && y <= 4) ? (z >> (y - 1)) & 1 : 0;
            end
        endcase
        flg = ((r >= 8) ? 8 : 0) + ((r == 0) ? 4 : 0) + (c ? 2 : 0) + (v ? 1 : 0);
    endfunction

    function automatic void exp_segs(input int md, input int r, input int flg, input int op,
                                     input int z, input int y,
                                     output logic [6:0] a, output logic [6:0] b);
        case (md)
            0: begin a = font[r]; b = font[op]; end
            1: begin a = font[z]; b = font[y]; end
            2: begin a = font[r]; b = font[flg]; end
            default: begin a = 7'h7F; b = 7'h7F; end
        endcase
    endfunction

    task automatic drive(input int z, input int y, input int md);
        bus.Z    = 4'(z);
        bus.Y    = 4'(y);
        bus.mode = 2'(md);
        @(posedge clk);
        #1;
    endtask

    // Hold the key low for n clocks then release; long holds count as one press.
    task automatic press(input int n);
        bus.btn_change = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        bus.btn_change = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (n >= HOLD) m_op = (m_op + 1) % 8;
    endtask

    task automatic test_reset;
        logic [6:0] ea, eb;
        int r, f;
        bus.btn_change = 1'b1;
        bus.mode = 2'b00;
        bus.Z = 4'd1;
        bus.Y = 4'd1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.out !== 4'd0 || bus.segA !== 7'h7F || bus.segB !== 7'h7F) begin
            miscompares++;
            $display("FAIL reset_state: got out=%h segA=%h segB=%h expected 0 7f 7f",
                     bus.out, bus.segA, bus.segB);
        end
        rst = 1'b0;
        m_op = 0;
        drive(1, 1, 0);
        model(m_op, 1, 1, r, f);
        exp_segs(0, r, f, m_op, 1, 1, ea, eb);
        vectors++;
        if (bus.out !== 4'(r) || bus.segA !== ea || bus.segB !== eb || bus.segA !== 7'h24) begin
            miscompares++;
            $display("FAIL first_add: got out=%h segA=%h segB=%h expected %h %h %h",
                     bus.out, bus.segA, bus.segB, r[3:0], ea, eb);
        end
    endtask

    task automatic test_add_flags;
        int zs[2] = '{7, 15};
        logic [6:0] fa[2] = '{7'h00, 7'h40};
        logic [6:0] fb[2] = '{7'h10, 7'h02};
        int r, f, z, y, md;
        logic [6:0] ea, eb;
        for (int i = 0; i < 2; i++) begin
            drive(zs[i], 1, 2);
            vectors++;
            if (bus.segA !== fa[i] || bus.segB !== fb[i]) begin
                miscompares++;
                $display("FAIL add_flags_%0d: got segA=%h segB=%h expected %h %h",
                         i, bus.segA, bus.segB, fa[i], fb[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            z  = $urandom_range(0, 15);
            y  = $urandom_range(0, 15);
            md = $urandom_range(0, 2);
            model(m_op, z, y, r, f);
            exp_segs(md, r, f, m_op, z, y, ea, eb);
            drive(z, y, md);
            vectors++;
            if (bus.out !== 4'(r) || bus.segA !== ea || bus.segB !== eb) begin
                miscompares++;
                $display("FAIL add_rand z=%0d y=%0d m=%0d: got %h %h %h expected %h %h %h",
                         z, y, md, bus.out, bus.segA, bus.segB, r[3:0], ea, eb);
            end
        end
    endtask

    task automatic test_button;
        int r, f;
        logic [6:0] ea, eb;
        press(HOLD);
        drive(1, 1, 0);
        vectors++;
        if (bus.out !== 4'd0 || bus.segB !== font[1]) begin
            miscompares++;
            $display("FAIL press_to_sub: got out=%h segB=%h expected 0 %h",
                     bus.out, bus.segB, font[1]);
        end
        drive(0, 1, 2);
        model(m_op, 0, 1, r, f);
        vectors++;
        if (bus.out !== 4'hF || bus.segB !== font[f] || f != 10) begin
            miscompares++;
            $display("FAIL sub_borrow: got out=%h segB=%h expected f %h", bus.out, bus.segB, font[10]);
        end
        press(10);
        press(2**DEB_W - 2);
        model(m_op, 3, 5, r, f);
        exp_segs(0, r, f, m_op, 3, 5, ea, eb);
        drive(3, 5, 0);
        vectors++;
        if (bus.segB !== font[1] || bus.out !== 4'(r) || bus.segA !== ea) begin
            miscompares++;
            $display("FAIL bounce_ignored: got out=%h segB=%h expected %h %h", bus.out, bus.segB, r[3:0], eb);
        end
    endtask

    task automatic test_all_ops;
        int dop[9] = '{2, 2, 6, 7, 0, 1, 3, 4, 5};
        int dz[9]  = '{5, 4, 9, 9, 7, 0, 12, 5, 15};
        int dy[9]  = '{3, 4, 1, 4, 1, 1, 10, 10, 5};
        int start, r, f, z, y, md;
        logic [6:0] ea, eb;
        start = m_op;
        for (int p = 0; p < 8; p++) begin
            press(HOLD);
            for (int k = 0; k < 12; k++) begin
                if (k < 9 && dop[k] != m_op) continue;
                if (k < 9) begin
                    z = dz[k]; y = dy[k]; md = 2;
                end else begin
                    z = $urandom_range(0, 15); y = $urandom_range(0, 15); md = $urandom_range(0, 2);
                end
                model(m_op, z, y, r, f);
                exp_segs(md, r, f, m_op, z, y, ea, eb);
                drive(z, y, md);
                vectors++;
                if (bus.out !== 4'(r) || bus.segA !== ea || bus.segB !== eb) begin
                    miscompares++;
                    $display("FAIL op%0d z=%0d y=%0d m=%0d: got %h %h %h expected %h %h %h",
                             m_op, z, y, md, bus.out, bus.segA, bus.segB, r[3:0], ea, eb);
                end
            end
        end
        drive(2, 3, 0);
        vectors++;
        if (bus.segB !== font[start]) begin
            miscompares++;
            $display("FAIL op_wrap: got segB=%h expected %h", bus.segB, font[start]);
        end
    endtask

    task automatic test_display;
        int r, f;
        drive(10, 3, 1);
        vectors++;
        if (bus.segA !== 7'h08 || bus.segB !== 7'h30) begin
            miscompares++;
            $display("FAIL disp_operands: got %h %h expected 08 30", bus.segA, bus.segB);
        end
        drive(6, 2, 3);
        model(m_op, 6, 2, r, f);
        vectors++;
        if (bus.segA !== 7'h7F || bus.segB !== 7'h7F || bus.out !== 4'(r)) begin
            miscompares++;
            $display("FAIL disp_off: got %h %h out=%h expected 7f 7f %h",
                     bus.segA, bus.segB, bus.out, r[3:0]);
        end
    endtask

    task automatic test_reset_mid;
        int r, f;
        while (m_op != 3) press(HOLD);
        drive(1, 2, 0);
        vectors++;
        if (bus.segB !== font[3]) begin
            miscompares++;
            $display("FAIL op_three: got segB=%h expected %h", bus.segB, font[3]);
        end
        bus.btn_change = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        m_op = 0;
        vectors++;
        if (bus.out !== 4'd0 || bus.segA !== 7'h7F || bus.segB !== 7'h7F) begin
            miscompares++;
            $display("FAIL reset_mid: got out=%h segA=%h segB=%h expected 0 7f 7f",
                     bus.out, bus.segA, bus.segB);
        end
        bus.btn_change = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (HOLD + 5) @(posedge clk);
        #1;
        drive(1, 2, 0);
        model(m_op, 1, 2, r, f);
        vectors++;
        if (bus.segB !== font[0] || bus.out !== 4'(r)) begin
            miscompares++;
            $display("FAIL no_advance: got segB=%h out=%h expected %h %h",
                     bus.segB, bus.out, font[0], r[3:0]);
        end
        bus.btn_change = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (HOLD + 5) @(posedge clk);
        #1;
        bus.btn_change = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        m_op = 1;
        drive(1, 2, 0);
        vectors++;
        if (bus.segB !== font[1]) begin
            miscompares++;
            $display("FAIL held_through_reset: got segB=%h expected %h", bus.segB, font[1]);
        end
    endtask

    initial begin
        test_reset();
        test_add_flags();
        test_button();
        test_all_ops();
        test_display();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
